// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin burst arbiter sharing single-port data_mem.
// Optional DMEM_ARB_PRIO_EN: requester 0 gets fixed, preempting priority.
module dmem_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wdme,
  output logic [DATA_W-1:0]        mem_wd,
  input  logic [DATA_W-1:0]        mem_rd
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [BW-1:0] LAST    = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] PTR_RST = OW'(NREQ - 1);
  localparam logic [OW:0]   NREQ_W  = (OW+1)'(NREQ);

  logic [0:0]        state;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     ptr;
  logic [OW-1:0]     win;
  logic [OW:0]       sum;
  logic [BW-1:0]     beat_cnt;
  logic [NREQ-1:0]   rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  logic            busy;
  logic            any_req;
  logic            own_req;
  logic            own_we;
  logic            beat;
  logic            rd_beat;
  logic            last;
  logic            preempt;
  logic            ptr_upd;
  logic            done;
  logic [NREQ-1:0] own_oh;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Scan ptr+NREQ down to ptr+1 so the nearest requester after ptr wins.
  always_comb begin
    win = ptr;
    sum = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (OW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (req[sum[OW-1:0]]) win = sum[OW-1:0];
    end
`ifdef DMEM_ARB_PRIO_EN
    if (req[0]) win = '0;
`endif
  end

  assign busy    = (state == BUSY);
  assign any_req = |req;
  assign own_req = req[owner];
  assign own_we  = we[owner];
  assign own_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign beat    = busy & own_req;
  assign rd_beat = beat & ~own_we;
  assign last    = (beat_cnt == LAST);

`ifdef DMEM_ARB_PRIO_EN
  assign preempt = beat & (owner != '0) & req[0];
  assign ptr_upd = (owner != '0);
`else
  assign preempt = 1'b0;
  assign ptr_upd = 1'b1;
`endif

  assign done = busy & (~own_req | (beat & (last | preempt)));

  assign gnt      = busy ? own_oh : '0;
  assign mem_a    = busy ? addr_a[owner] : '0;
  assign mem_wd   = busy ? wdata_a[owner] : '0;
  assign mem_wdme = beat & own_we;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

  // busy & ~done implies req[owner], i.e. a beat that continues the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= PTR_RST;
      beat_cnt <= '0;
    end else begin
      unique case (1'b1)
        !busy: begin
          if (any_req) begin
            state    <= BUSY;
            owner    <= win;
            beat_cnt <= '0;
          end
        end
        busy & done: begin
          state <= IDLE;
          if (ptr_upd) ptr <= owner;
        end
        busy & ~done: begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_beat ? own_oh : '0;
      if (rd_beat) rdata_q <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter
// against a transaction-level model with its own reference memory.
module tb_dmem_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MB   = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_v;
  logic [NREQ-1:0]    we_v;
  logic [NREQ*AW-1:0] addr_v;
  logic [NREQ*DW-1:0] wdata_v;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_a;
  logic               mem_wdme;
  logic [DW-1:0]      mem_wd;
  logic [DW-1:0]      mem_rd;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int n_chk;
  int n_pass;

  bit            m_busy;
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  logic [2:0]    m_rv;
  logic [DW-1:0] m_rd;

  dmem_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req_v), .we(we_v),
    .addr(addr_v), .wdata(wdata_v),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_a(mem_a), .mem_wdme(mem_wdme),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_wdme) mem[mem_a[7:0]] <= mem_wd;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] a_of(input int i);
    return addr_v[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(input int i);
    return wdata_v[i*DW +: DW];
  endfunction

  task automatic set_rq(input int i, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    req_v[i] = r;
    we_v[i]  = w;
    addr_v[i*AW +: AW]  = a;
    wdata_v[i*DW +: DW] = d;
  endtask

  task automatic clear_rq();
    req_v = '0;
    we_v  = '0;
    addr_v  = '0;
    wdata_v = '0;
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = NREQ - 1;
    m_cnt   = 0;
    m_rv    = '0;
    m_rd    = '0;
  endtask

  task automatic end_burst(input int o);
    m_busy = 0;
`ifdef DMEM_ARB_PRIO_EN
    if (o != 0) m_ptr = o;
`else
    m_ptr = o;
`endif
  endtask

  // One clock edge of the arbiter, as the rules describe it.
  task automatic model_step();
    int o;
    int w;
    bit pre;
    logic [AW-1:0] ra;
    m_rv = '0;
    if (!m_busy) begin
      if (req_v != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`ifdef DMEM_ARB_PRIO_EN
        if (req_v[0]) w = 0;
`endif
        m_owner = w;
        m_cnt   = 0;
        m_busy  = 1;
      end
    end else begin
      o = m_owner;
      if (!req_v[o]) begin
        end_burst(o);
      end else begin
        ra = a_of(o);
        if (we_v[o]) ref_mem[ra[7:0]] = d_of(o);
        else begin
          m_rv[o] = 1'b1;
          m_rd    = ref_mem[ra[7:0]];
        end
        m_cnt++;
        pre = 0;
`ifdef DMEM_ARB_PRIO_EN
        pre = (o != 0) && req_v[0];
`endif
        if (m_cnt == MB || pre) end_burst(o);
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    int o;
    logic [2:0]    g_exp;
    logic          w_exp;
    logic [AW-1:0] a_exp;
    logic [DW-1:0] d_exp;
    #1;
    o     = m_owner;
    g_exp = m_busy ? (3'b001 << o) : 3'b000;
    w_exp = m_busy && req_v[o] && we_v[o];
    a_exp = m_busy ? a_of(o) : '0;
    d_exp = m_busy ? d_of(o) : '0;
    check("gnt", gnt, g_exp);
    check("mem_wdme", mem_wdme, w_exp);
    check("mem_a", mem_a, a_exp);
    check("mem_wd", mem_wd, d_exp);
    check("rvalid", rvalid, m_rv);
    check("rdata", rdata, m_rd);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_gnt0", gnt, 0);
    check("rst_rvalid0", rvalid, 0);
    check("rst_wdme0", mem_wdme, 0);
    check("rst_mem_a0", mem_a, 0);
    check("rst_rdata0", rdata, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [9:0] gbits;
  logic [2:0] g;
  logic [2:0] lastg;
  int         order[$];
  int         fexp[6];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b0;
    clear_rq();
    req_v = 3'b011;
    model_reset();
    @(negedge clk);

    // reset with requests pending, then requester 0 granted
    do_reset();
    cyc();
    check("rst_first_gnt", gnt, 3'b001);
    cyc();

    // requester 1 writes then reads 0x40
    clear_rq();
    do_reset();
    set_rq(1, 1, 1, 32'h40, 32'hDEADBEEF);
    cyc();
    #1;
    check("wr_wdme", mem_wdme, 1);
    check("wr_addr", mem_a, 32'h40);
    cyc();
    set_rq(1, 1, 0, 32'h40, 32'h0);
    #1;
    check("rd_wdme", mem_wdme, 0);
    cyc();
    clear_rq();
    #1;
    check("rd_rvalid", rvalid, 3'b010);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    cyc();
    #1;
    check("rd_pulse", rvalid, 3'b000);
    cyc();

    // burst cap: 4 beats, 1 idle, regrant
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_rq(0, 1, 0, i, 0);
      #1;
      gbits[i] = gnt[0];
      cyc();
    end
    check("burst_gnt", gbits, 10'b1111011110);
    clear_rq();
    cyc();
    cyc();

    // fairness: one beat per grant, all requesters busy
    do_reset();
    lastg = '0;
    for (int c = 0; c < 24; c++) begin
      g = gnt;
      if (g != 0 && lastg == 0)
        for (int i = 0; i < NREQ; i++) if (g[i]) order.push_back(i);
      req_v = 3'b111;
      if (g != 0 && g == lastg) req_v = req_v & ~g;
      lastg = g;
      cyc();
    end
    fexp = '{0, 1, 2, 0, 1, 2};
    check("fair_count", order.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (k < order.size())
        check($sformatf("fair_%0d", k), order[k], fexp[k]);
    clear_rq();
    cyc();
    cyc();

    // early drop by requester 1
    do_reset();
    set_rq(1, 1, 1, 32'h5, 32'h1234);
    cyc();
    check("drop_gnt1", gnt, 3'b010);
    req_v[1] = 1'b0;
    set_rq(0, 1, 0, 32'h5, 0);
    #1;
    check("drop_wdme", mem_wdme, 0);
    cyc();
    check("drop_idle", gnt, 3'b000);
    check("drop_rvalid", rvalid, 3'b000);
    cyc();
    check("drop_srv0", gnt, 3'b001);
    cyc();
    clear_rq();
    cyc();

`ifdef DMEM_ARB_PRIO_EN
    // requester 0 preempts requester 1 mid-burst
    do_reset();
    set_rq(1, 1, 0, 32'h7, 0);
    cyc();
    cyc();
    set_rq(0, 1, 0, 32'h8, 0);
    cyc();
    check("prio_idle", gnt, 3'b000);
    cyc();
    check("prio_gnt0", gnt, 3'b001);
    cyc();
    clear_rq();
    cyc();
`endif

    // random traffic with a reset in the middle
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_rq(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 31), $urandom);
      if (c == 300) do_reset();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
